// File: rtl/ram_bus_master_if.sv
// CPU-side request/ready handshake of ram_bus_master: master drives requests, slave serves them.
interface ram_bus_master_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req;
  logic                  we;
  logic                  wide;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic [15:0]           rdata;
  logic                  ready;
  logic                  done;
  logic                  err;

  modport master (
    output req, we, wide, addr, wdata,
    input  rdata, ready, done, err
  );

  modport slave (
    input  req, we, wide, addr, wdata,
    output rdata, ready, done, err
  );
endinterface

// File: rtl/ram_bus_master.sv
// Byte / 16-bit little-endian bus master for the shared 8-bit tri-state RAM bus.
// Optional feature macro RAM_BUS_MASTER_ALIGN_TRAP_EN: trap misaligned wide requests with done+err.
module ram_bus_master #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_bus_master_if.slave       cpu,
  output logic [ADDR_WIDTH-1:0] address_bus,
  inout  wire  [7:0]            data_bus,
  output logic                  enable,
  output logic                  write,
  output logic                  read
);
  typedef enum logic [2:0] {IDLE, WR0, WR1, RA0, RD0A1, RD1, RD0} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] a_q, addr_nxt;
  logic                  wide_q;
  logic [7:0]            wd_hi_q, lo_q, dout_q, dout_nxt;
  logic [15:0]           rdata_nxt;
  logic                  drv_q, drv_nxt, en_nxt, wr_nxt, rd_nxt, done_nxt;
  logic                  accept, trap;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign accept   = cpu.req & cpu.ready;
  assign data_bus = drv_q ? dout_q : 8'bz;

`ifdef RAM_BUS_MASTER_ALIGN_TRAP_EN
  assign trap = cpu.wide & cpu.addr[0];

  always_ff @(posedge clk) begin
    if (reset) cpu.err <= 1'b0;
    else       cpu.err <= accept & trap;
  end
`else
  assign trap    = 1'b0;
  assign cpu.err = 1'b0;
`endif

  // Next-state logic also produces the next value of every RAM-side output register.
  always_comb begin
    state_nxt = state;
    addr_nxt  = address_bus;
    dout_nxt  = dout_q;
    rdata_nxt = cpu.rdata;
    drv_nxt   = 1'b0;
    en_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (trap) begin
            done_nxt = 1'b1;
          end else if (cpu.we) begin
            state_nxt = WR0;
            addr_nxt  = cpu.addr;
            dout_nxt  = cpu.wdata[7:0];
            drv_nxt   = 1'b1;
            en_nxt    = 1'b1;
            wr_nxt    = 1'b1;
          end else begin
            state_nxt = RA0;
            addr_nxt  = cpu.addr;
            en_nxt    = 1'b1;
            rd_nxt    = 1'b1;
          end
        end
      end
      WR0: begin
        if (wide_q) begin
          state_nxt = WR1;
          addr_nxt  = addr_inc(a_q);
          dout_nxt  = wd_hi_q;
          drv_nxt   = 1'b1;
          en_nxt    = 1'b1;
          wr_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      WR1: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      RA0: begin
        rd_nxt = 1'b1;
        if (wide_q) begin
          // Second address phase overlaps the first byte's data phase.
          state_nxt = RD0A1;
          addr_nxt  = addr_inc(a_q);
          en_nxt    = 1'b1;
        end else begin
          state_nxt = RD0;
        end
      end
      RD0A1: begin
        state_nxt = RD1;
        rd_nxt    = 1'b1;
      end
      RD1: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        rdata_nxt = {data_bus, lo_q};
      end
      RD0: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        rdata_nxt = {8'h00, data_bus};
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu.ready   <= 1'b1;
      cpu.done    <= 1'b0;
      cpu.rdata   <= 16'h0000;
      address_bus <= '0;
      enable      <= 1'b0;
      write       <= 1'b0;
      read        <= 1'b0;
      drv_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu.ready   <= (state_nxt == IDLE);
      cpu.done    <= done_nxt;
      cpu.rdata   <= rdata_nxt;
      address_bus <= addr_nxt;
      enable      <= en_nxt;
      write       <= wr_nxt;
      read        <= rd_nxt;
      drv_q       <= drv_nxt;
    end
  end

  // Request capture and byte staging carry no reset; they are qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= cpu.addr;
      wide_q  <= cpu.wide;
      wd_hi_q <= cpu.wdata[15:8];
    end
    if (state == RD0A1) lo_q <= data_bus;
    dout_q <= dout_nxt;
  end
endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master against a behavioural registered-read RAM.
module tb_ram_bus_master;
  localparam int AW = 12;

  typedef struct {
    logic [15:0] rdata;
    int          lat;
    logic        err;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_bus;
  wire  [7:0]    data_bus;
  logic          enable, write, read;

  ram_bus_master_if #(.ADDR_WIDTH(AW)) cpu ();

  ram_bus_master #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .cpu(cpu), .address_bus(address_bus),
    .data_bus(data_bus), .enable(enable), .write(write), .read(read)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (enable && write) mem[address_bus] <= data_bus;
    if (enable && read)  ram_q <= mem[address_bus];
  end
  assign data_bus = read ? ram_q : 8'bz;

  int   cyc = 0;
  int   acc_q[$];
  txn_t obs_q[$];
  txn_t exp_q[$];
  int   rw_both = 0, idle_active = 0, bus_conflict = 0, en_cnt = 0;
  int   n_tests = 0, n_fail = 0;
  logic [7:0]  ref_mem [0:(1<<AW)-1];
  logic [15:0] last_rd = 16'h0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) acc_q.delete();
    else if (cpu.req && cpu.ready) acc_q.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (!reset) begin
      int l;
      if (read && write) rw_both <= rw_both + 1;
      if (cpu.ready && (enable || read || write)) idle_active <= idle_active + 1;
      if (read && data_bus !== ram_q) bus_conflict <= bus_conflict + 1;
      if (enable) en_cnt <= en_cnt + 1;
      if (cpu.done) begin
        l = -1;
        if (acc_q.size() > 0) l = cyc - acc_q.pop_front() + 1;
        obs_q.push_back('{rdata: cpu.rdata, lat: l, err: cpu.err});
      end
    end
  end

  task automatic model_push(input logic w, input logic wd, input logic [AW-1:0] a,
                            input logic [15:0] d);
    logic [AW-1:0] a1;
    logic          trap;
    a1 = a + 1'b1;
`ifdef RAM_BUS_MASTER_ALIGN_TRAP_EN
    trap = wd & a[0];
`else
    trap = 1'b0;
`endif
    if (trap) begin
      exp_q.push_back('{rdata: last_rd, lat: 1, err: 1'b1});
    end else if (w) begin
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[a1] = d[15:8];
      exp_q.push_back('{rdata: last_rd, lat: wd ? 3 : 2, err: 1'b0});
    end else begin
      last_rd = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      exp_q.push_back('{rdata: last_rd, lat: wd ? 4 : 3, err: 1'b0});
    end
  endtask

  task automatic send(input logic w, input logic wd, input logic [AW-1:0] a,
                      input logic [15:0] d, input bit hold, output int acc_at);
    model_push(w, wd, a, d);
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = w; cpu.wide = wd; cpu.addr = a; cpu.wdata = d;
    for (int i = 0; i < 50 && cpu.ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    #1;
    acc_at = cyc;
    if (!hold) cpu.req = 1'b0;
  endtask

  task automatic get_obs(output txn_t o, output bit ok);
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    ok = (obs_q.size() > 0);
    o  = '{rdata: 16'hxxxx, lat: -1, err: 1'bx};
    if (ok) o = obs_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.wide = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({cpu.ready, cpu.done, cpu.err, enable, write, read} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/done/err/en/wr/rd=%b expected 100000",
               {cpu.ready, cpu.done, cpu.err, enable, write, read});
    end
    n_tests++;
    if (cpu.rdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0000", cpu.rdata);
    end
    n_tests++;
    if (address_bus !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 000", address_bus);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte();
    txn_t o, e; bit ok; int t;
    send(1'b1, 1'b0, 12'h010, 16'h00A5, 1'b0, t);
    send(1'b0, 1'b0, 12'h010, 16'h0000, 1'b0, t);
    for (int k = 0; k < 2; k++) begin
      get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
      if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
        n_fail++;
        $display("FAIL byte_txn%0d: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
                 k, ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
      end
    end
    n_tests++;
    if (mem[12'h010] !== 8'hA5) begin
      n_fail++; $display("FAIL byte_mem: [010]=%h expected a5", mem[12'h010]);
    end
  endtask

  task automatic test_wide();
    txn_t o, e; bit ok; int t, en0;
    send(1'b1, 1'b1, 12'h100, 16'hBEEF, 1'b0, t);
    get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
    if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
      n_fail++;
      $display("FAIL wide_wr: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
               ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
    end
    n_tests++;
    if ({mem[12'h101], mem[12'h100]} !== 16'hBEEF) begin
      n_fail++; $display("FAIL wide_mem: [101:100]=%h%h expected beef", mem[12'h101], mem[12'h100]);
    end
    en0 = en_cnt;
    send(1'b0, 1'b1, 12'h100, 16'h0000, 1'b0, t);
    get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
    if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
      n_fail++;
      $display("FAIL wide_rd: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
               ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
    end
    n_tests++;
    if (en_cnt - en0 != 2) begin
      n_fail++; $display("FAIL wide_rd_enable: enable high %0d cycles expected 2", en_cnt - en0);
    end
  endtask

`ifndef RAM_BUS_MASTER_ALIGN_TRAP_EN
  task automatic test_wrap();
    txn_t o, e; bit ok; int t;
    send(1'b1, 1'b1, 12'hFFF, 16'h1234, 1'b0, t);
    send(1'b0, 1'b1, 12'hFFF, 16'h0000, 1'b0, t);
    for (int k = 0; k < 2; k++) begin
      get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
      if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
        n_fail++;
        $display("FAIL wrap_txn%0d: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
                 k, ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
      end
    end
    n_tests++;
    if (mem[12'hFFF] !== 8'h34 || mem[12'h000] !== 8'h12) begin
      n_fail++; $display("FAIL wrap_mem: [fff]=%h [000]=%h expected 34 12", mem[12'hFFF], mem[12'h000]);
    end
  endtask
`else
  task automatic test_align_trap();
    txn_t o, e; bit ok; int t, en0;
    logic [7:0] m11, m12;
    m11 = mem[12'h011]; m12 = mem[12'h012]; en0 = en_cnt;
    send(1'b1, 1'b1, 12'h011, 16'h5A5A, 1'b0, t);
    send(1'b0, 1'b1, 12'h011, 16'h0000, 1'b0, t);
    for (int k = 0; k < 2; k++) begin
      get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
      if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
        n_fail++;
        $display("FAIL trap_txn%0d: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
                 k, ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
      end
    end
    n_tests++;
    if (en_cnt != en0 || mem[12'h011] !== m11 || mem[12'h012] !== m12) begin
      n_fail++;
      $display("FAIL trap_nocycle: enable cycles=%0d [011]=%h [012]=%h expected 0 %h %h",
               en_cnt - en0, mem[12'h011], mem[12'h012], m11, m12);
    end
  endtask
`endif

  task automatic test_back_to_back();
    txn_t o, e; bit ok; int acc [3];
    int c0, r0;
    logic [AW-1:0] addrs [3];
    addrs[0] = 12'h010; addrs[1] = 12'h100; addrs[2] = 12'h101;
    c0 = bus_conflict; r0 = rw_both;
    for (int k = 0; k < 3; k++) send(1'b0, 1'b0, addrs[k], 16'h0000, 1'b1, acc[k]);
    cpu.req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
      if (!ok || o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
        n_fail++;
        $display("FAIL b2b_txn%0d: ok=%0b rdata=%h lat=%0d err=%b expected rdata=%h lat=%0d err=%b",
                 k, ok, o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (acc[k+1] - acc[k] != 3) begin
        n_fail++; $display("FAIL b2b_gap%0d: accept spacing %0d expected 3", k, acc[k+1] - acc[k]);
      end
    end
    n_tests++;
    if (bus_conflict != c0 || rw_both != r0) begin
      n_fail++;
      $display("FAIL b2b_bus: conflicts=%0d rw_both=%0d expected 0 0", bus_conflict - c0, rw_both - r0);
    end
  endtask

  task automatic test_reset_mid();
    txn_t o, e; bit ok; int t;
    send(1'b1, 1'b0, 12'h201, 16'h0077, 1'b0, t);
    get_obs(o, ok); e = exp_q.pop_front(); n_tests++;
    if (!ok || o.lat != e.lat) begin
      n_fail++; $display("FAIL mid_setup: ok=%0b lat=%0d expected lat=%0d", ok, o.lat, e.lat);
    end
    send(1'b1, 1'b1, 12'h200, 16'hC3D2, 1'b0, t);
    void'(exp_q.pop_back());
    ref_mem[12'h201] = 8'h77;
    // Sampled at the edge that would otherwise enter WR1.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++;
    if ({enable, write, cpu.ready, cpu.done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_abort: en/wr/ready/done=%b expected 0010", {enable, write, cpu.ready, cpu.done});
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL mid_nodone: %0d completions seen expected 0", obs_q.size());
      obs_q.delete();
    end
    n_tests++;
    if (mem[12'h200] !== 8'hD2 || mem[12'h201] !== 8'h77) begin
      n_fail++; $display("FAIL mid_mem: [200]=%h [201]=%h expected d2 77", mem[12'h200], mem[12'h201]);
    end
  endtask

  task automatic test_bus_rules();
    n_tests++;
    if (rw_both != 0 || idle_active != 0 || bus_conflict != 0) begin
      n_fail++;
      $display("FAIL bus_rules: rw_both=%0d idle_active=%0d conflicts=%0d expected 0 0 0",
               rw_both, idle_active, bus_conflict);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_wide();
`ifndef RAM_BUS_MASTER_ALIGN_TRAP_EN
    test_wrap();
`else
    test_align_trap();
`endif
    test_back_to_back();
    test_reset_mid();
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
